// File: rtl/screening_scanner.sv
// Sequential bit scanner: accepts a word and emits its set bits one per handshake,
// junior-first or senior-first, as a one-hot word plus its binary index.
module screening_scanner #(
  parameter int WORD_WIDTH = 8,
  localparam int INDEX_WIDTH = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   clear_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [WORD_WIDTH-1:0]  data_i,
  input  logic                   c_i,
  input  logic                   mode_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WORD_WIDTH-1:0]  out_data_o,
  output logic [INDEX_WIDTH-1:0] out_index_o,
  output logic                   out_last_o,
  output logic                   c_o
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                 state;
  logic [WORD_WIDTH-1:0]  res;
  logic                   mode;

  logic [INDEX_WIDTH-1:0] pick_idx;
  logic [WORD_WIDTH-1:0]  pick;
  logic                   last;
  logic                   scanning;
  logic                   load;
  logic                   consume;

  // Position of the lowest (senior=0) or highest (senior=1) set bit; 0 when v is empty.
  function automatic logic [INDEX_WIDTH-1:0] screen_index(input logic [WORD_WIDTH-1:0] v,
                                                          input logic senior);
    logic [INDEX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (senior && v[i]) idx = INDEX_WIDTH'(i);
    end
    for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
      if (!senior && v[i]) idx = INDEX_WIDTH'(i);
    end
    return idx;
  endfunction

  function automatic logic [WORD_WIDTH-1:0] one_hot(input logic [INDEX_WIDTH-1:0] idx,
                                                    input logic nonzero);
    logic [WORD_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (nonzero && (INDEX_WIDTH'(i) == idx)) r[i] = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    scanning = (state == SCAN);
    pick_idx = screen_index(res, mode);
    pick     = one_hot(pick_idx, |res);
    // Last beat when nothing remains after removing the current bit (covers the empty word).
    last     = ((res & ~pick) == '0);

    out_valid_o = scanning;
    out_data_o  = scanning ? pick : '0;
    out_index_o = scanning ? pick_idx : '0;
    out_last_o  = scanning & last;
    c_o         = scanning & (res == '0);

    in_ready_o  = !clear_i && (!scanning || (out_ready_i && last));
    load        = in_valid_i & in_ready_o;
    consume     = scanning & out_ready_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      res   <= '0;
      mode  <= 1'b0;
    end else if (clear_i) begin
      state <= IDLE;
      res   <= '0;
    end else if (load) begin
      state <= SCAN;
      res   <= c_i ? data_i : '0;
      mode  <= mode_i;
    end else if (consume) begin
      res <= res & ~pick;
      if (last) state <= IDLE;
    end
  end

endmodule

// File: tb/tb_screening_scanner.sv
// Directed table-driven bench for screening_scanner (WORD_WIDTH=8) with
// hand-written sequences for reset behaviour.
module tb_screening_scanner;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       clear_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] data_i;
  logic       c_i;
  logic       mode_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [7:0] out_data_o;
  logic [2:0] out_index_o;
  logic       out_last_o;
  logic       c_o;

  int checks = 0;
  int errors = 0;

  screening_scanner #(.WORD_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clear_i(clear_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .data_i(data_i),
    .c_i(c_i), .mode_i(mode_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_index_o(out_index_o), .out_last_o(out_last_o), .c_o(c_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       c;
    logic       m;
    logic       ordy;
    logic       clr;
    logic       ir;
    logic       ov;
    logic [7:0] od;
    logic [2:0] oi;
    logic       ol;
    logic       co;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [7:0] d, logic c, logic m, logic ordy,
                              logic clr, logic ir, logic ov, logic [7:0] od,
                              logic [2:0] oi, logic ol, logic co);
    vec_t v;
    v.iv = iv; v.d = d; v.c = c; v.m = m; v.ordy = ordy; v.clr = clr;
    v.ir = ir; v.ov = ov; v.od = od; v.oi = oi; v.ol = ol; v.co = co;
    return v;
  endfunction

  task automatic check_out(string name, logic ir, logic ov, logic [7:0] od,
                           logic [2:0] oi, logic ol, logic co);
    logic [13:0] got, exp;
    got = {in_ready_o, out_valid_o, out_data_o, out_index_o, out_last_o, c_o};
    exp = {ir, ov, od, oi, ol, co};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got rdy=%b vld=%b data=%h idx=%0d last=%b c=%b, expected rdy=%b vld=%b data=%h idx=%0d last=%b c=%b",
               name, in_ready_o, out_valid_o, out_data_o, out_index_o, out_last_o, c_o,
               ir, ov, od, oi, ol, co);
    end
  endtask

  initial begin
    //            iv  d      c  m  ordy clr | ir ov od     oi ol co
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,   1, 0, 8'h00, 0, 0, 0)); // 0 idle after reset
    vecs.push_back(mk(1, 8'hA4, 1, 0, 1, 0,   1, 0, 8'h00, 0, 0, 0)); // 1 load A4 junior
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,   0, 1, 8'h04, 2, 0, 0)); // 2
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,   0, 1, 8'h20, 5, 0, 0)); // 3
    vecs.push_back(mk(1, 8'hA4, 1, 1, 1, 0,   1, 1, 8'h80, 7, 1, 0)); // 4 last + load A4 senior
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,   0, 1, 8'h80, 7, 0, 0)); // 5
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,   0, 1, 8'h20, 5, 0, 0)); // 6
    vecs.push_back(mk(1, 8'h00, 1, 0, 1, 0,   1, 1, 8'h04, 2, 1, 0)); // 7 last + load 00
    vecs.push_back(mk(1, 8'hFF, 0, 0, 1, 0,   1, 1, 8'h00, 0, 1, 1)); // 8 empty + load FF c=0
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,   1, 1, 8'h00, 0, 1, 1)); // 9 empty
    vecs.push_back(mk(1, 8'h81, 1, 0, 1, 0,   1, 0, 8'h00, 0, 0, 0)); // 10 idle, load 81
    vecs.push_back(mk(1, 8'h55, 1, 1, 0, 0,   0, 1, 8'h01, 0, 0, 0)); // 11 stall, mode flips
    vecs.push_back(mk(1, 8'h55, 1, 1, 0, 0,   0, 1, 8'h01, 0, 0, 0)); // 12 stall
    vecs.push_back(mk(1, 8'h55, 1, 1, 0, 0,   0, 1, 8'h01, 0, 0, 0)); // 13 stall
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0,   0, 1, 8'h01, 0, 0, 0)); // 14 taken
    vecs.push_back(mk(1, 8'h10, 1, 1, 1, 0,   1, 1, 8'h80, 7, 1, 0)); // 15 last + load 10
    vecs.push_back(mk(1, 8'h03, 1, 1, 1, 0,   1, 1, 8'h10, 4, 1, 0)); // 16 last + load 03
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,   0, 1, 8'h02, 1, 0, 0)); // 17
    vecs.push_back(mk(1, 8'hFF, 1, 0, 1, 0,   1, 1, 8'h01, 0, 1, 0)); // 18 last + load FF
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,   0, 1, 8'h01, 0, 0, 0)); // 19 FF beat 1
    vecs.push_back(mk(1, 8'h55, 1, 0, 1, 1,   0, 1, 8'h02, 1, 0, 0)); // 20 clear on beat 2
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,   1, 0, 8'h00, 0, 0, 0)); // 21 aborted
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,   1, 0, 8'h00, 0, 0, 0)); // 22 still idle

    rst_n_i = 1'b0; clear_i = 1'b0; in_valid_i = 1'b0; data_i = 8'h00;
    c_i = 1'b0; mode_i = 1'b0; out_ready_i = 1'b1;
    #1;
    check_out("reset_async", 1, 0, 8'h00, 0, 0, 0);
    repeat (2) @(negedge clk_i);
    check_out("reset_held", 1, 0, 8'h00, 0, 0, 0);
    rst_n_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid_i = vecs[i].iv; data_i = vecs[i].d; c_i = vecs[i].c;
      mode_i = vecs[i].m; out_ready_i = vecs[i].ordy; clear_i = vecs[i].clr;
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].ir, vecs[i].ov, vecs[i].od,
                vecs[i].oi, vecs[i].ol, vecs[i].co);
      @(negedge clk_i);
    end

    // Reset dropped in the middle of a scan
    in_valid_i = 1'b1; data_i = 8'hFF; c_i = 1'b1; mode_i = 1'b0;
    out_ready_i = 1'b0; clear_i = 1'b0;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    check_out("pre_reset_beat", 0, 1, 8'h01, 0, 0, 0);
    rst_n_i = 1'b0;
    #1;
    check_out("reset_midscan", 1, 0, 8'h00, 0, 0, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    out_ready_i = 1'b1;
    #1;
    check_out("post_reset_idle", 1, 0, 8'h00, 0, 0, 0);
    @(negedge clk_i);
    #1;
    check_out("post_reset_noscan", 1, 0, 8'h00, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/screening_scanner.md
# screening_scanner

Sequential, parametrised bit-scanner built on the screening function. It accepts a word and emits its set bits one per handshake, each as a one-hot word plus its binary index. Order is junior-first (LSB to MSB) or senior-first (MSB to LSB), selected per word. It sits between request/flag registers and serial consumers such as interrupt dispatch, round-robin grant sequencing and free-slot allocation, where the combinational screening primitives would give only one grant per word.

## Interface
Parameters:
- WORD_WIDTH, 8, width of input word and one-hot output; legal range ≥ 1
- INDEX_WIDTH, derived = max(1, $clog2(WORD_WIDTH)), width of out_index_o; not overridable

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous abort; discards the word being scanned
- in_valid_i  in  1  word offered
- in_ready_o  out  1  word can be accepted
- data_i  in  WORD_WIDTH  word to scan
- c_i  in  1  carry in; when 0 the word is treated as all-zero
- mode_i  in  1  0 = junior-first, 1 = senior-first; sampled with the word
- out_valid_o  out  1  beat available
- out_ready_i  in  1  consumer takes beat
- out_data_o  out  WORD_WIDTH  one-hot isolated bit, or 0
- out_index_o  out  INDEX_WIDTH  bit position of out_data_o, in original bit order (0 = LSB)
- out_last_o  out  1  final beat of the current word
- c_o  out  1  carry out; word held no set bit (c_i=0 or data_i=0)

## Operation
- State: FSM {IDLE, SCAN}, residual register res[WORD_WIDTH-1:0], mode register.
- Load occurs on in_valid_i & in_ready_o:
  - res ← c_i ? data_i : 0, and the mode register ← mode_i.
  - The FSM moves to SCAN.
- In SCAN:
  - out_valid_o=1.
  - out_data_o = lowest set bit of res (mode 0) or highest set bit of res (mode 1).
  - out_index_o = position of that bit.
  - out_last_o = (popcount(res) ≤ 1).
  - c_o = (res == 0).
- Empty word: exactly one beat, with out_data_o=0, out_index_o=0, out_last_o=1, c_o=1.
- Beat consumed on out_valid_o & out_ready_i:
  - res ← res & ~out_data_o.
  - If out_last_o, the FSM returns to IDLE, unless a new load occurs in the same cycle.
- in_ready_o = IDLE | (SCAN & out_ready_i & out_last_o).
  - This gives back-to-back words with no bubble.
  - There is a combinational path out_ready_i → in_ready_o.
- When out_valid_o=0, out_data_o, out_index_o, out_last_o and c_o are all 0.
- Outputs are stable while out_valid_o & ~out_ready_i. in_valid_i and data_i are don't-care unless in_ready_o=1.
- clear_i has priority over load and consume:
  - next state IDLE, res ← 0.
  - in_ready_o is forced to 0 in that cycle, so no word is accepted while clear_i=1.
- Mode is fixed per word. A mode_i change mid-scan has no effect.
- WORD_WIDTH=1: every non-empty word gives one beat, out_data_o=1, index 0, last=1.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system):
  - FSM=IDLE, res=0, mode=0.
  - in_ready_o=1; out_valid_o, out_data_o, out_index_o, out_last_o and c_o all 0.
- Load-to-first-beat latency: 1 cycle. A word accepted at edge N shows its first beat in the cycle after edge N.
- Throughput: k set bits → k beats in k cycles with out_ready_i held high. An empty word takes 1 cycle.
- Reset asserted mid-scan: outputs go to their reset values immediately, without waiting for a clock edge. The partial word is lost.
- No output depends combinationally on data_i or in_valid_i.

## Test plan
- WORD_WIDTH=8, mode 0, c_i=1, data 8'hA4, out_ready_i=1 → three consecutive beats:
  - 8'h04/idx 2
  - 8'h20/idx 5
  - 8'h80/idx 7 with last=1, c_o=0 throughout
  - in_ready_o=1 in the third beat.
- Same word, mode 1 → beats 8'h80/7, then 8'h20/5, then 8'h04/2 last.
- data 8'h00 with c_i=1, then data 8'hFF with c_i=0 → one beat each: out_data_o=0, idx 0, last=1, c_o=1.
- data 8'h81, mode 0, out_ready_i low for 3 cycles, then high → the 8'h01/0 beat is held stable 4 cycles. Then 8'h80/7 last.
- Back-to-back: 8'h10 then 8'h03 (mode 1), second word presented during the first word's last beat:
  - the second word is accepted in that same cycle;
  - the next cycle shows 8'h02/1, then 8'h01/0 last;
  - no idle cycle between words.
- Abort and reset:
  - clear_i pulsed during the second beat of 8'hFF → next cycle out_valid_o=0, in_ready_o=1, and no further beats.
  - rst_n_i dropped mid-scan → out_valid_o falls before the next edge, and state is IDLE after release.
